// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and result-width helpers.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_RES_W = 2 * DEFAULT_WIDTH;

  function automatic int result_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator/shift register and
// the final conditional negate, driven by load/step strobes from the FSM.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 signed_mode_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   prod_o
);

  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     sum;

  // The most-negative operand negates to itself, which reads correctly
  // as the unsigned magnitude 2^(WIDTH-1).
  assign a_neg    = signed_mode_i & a_i[WIDTH-1];
  assign b_neg    = signed_mode_i & b_i[WIDTH-1];
  assign mag_a_in = a_neg ? (~a_i + 1'b1) : a_i;
  assign mag_b_in = b_neg ? (~b_i + 1'b1) : b_i;

  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};

  always_comb begin
    mag_a_d  = mag_a_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    if (load_i) begin
      mag_a_d  = mag_a_in;
      mplier_d = mag_b_in;
      acc_d    = '0;
      neg_d    = a_neg ^ b_neg;
    end else if (step_i) begin
      // {carry, upper half} shifts right with the low half of the product
      if (mplier_q[0]) begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mag_a_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mag_a_q  <= mag_a_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
    end
  end

  assign prod_o = neg_q ? (~acc_q + 1'b1) : acc_q;

endmodule

// File: rtl/seq_multiplier_nb.sv
// Sequential WIDTH x WIDTH multiplier with start/busy/done handshake,
// unsigned or two's-complement; one product per WIDTH+2 cycles.
module seq_multiplier_nb
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Result
);

  localparam int              RES_W    = result_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic [RES_W-1:0]   result_q;

  logic               load;
  logic               step;
  logic [RES_W-1:0]   prod;

  assign load = (state_q == IDLE) && start;
  assign step = (state_q == RUN);

  seq_mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk           (clk),
    .rstn          (rstn),
    .load_i        (load),
    .step_i        (step),
    .signed_mode_i (signed_mode),
    .a_i           (A),
    .b_i           (B),
    .prod_o        (prod)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          done_q <= 1'b0;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          result_q <= prod;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q == RUN) || (state_q == DONE);
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_seq_multiplier_nb.sv
// Directed bench for seq_multiplier_nb at WIDTH=4 plus a WIDTH=8 spot sweep.
module tb_seq_multiplier_nb;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;

  logic       start4 = 1'b0, sm4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [7:0] res4;

  logic       start8 = 1'b0, sm8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [15:0] res8;

  int n_cmp = 0;
  int n_err = 0;

  seq_multiplier_nb #(.WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .signed_mode(sm4),
    .A(a4), .B(b4), .busy(busy4), .done(done4), .Result(res4)
  );

  seq_multiplier_nb #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .Result(res8)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request and returns at the negedge where done is seen;
  // lat counts clock edges after the sampling edge (20 = no done).
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                      output logic [7:0] res, output int lat);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b; sm4 = ~sm;
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = res4;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      output logic [15:0] res, output int lat);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; sm8 = ~sm;
    lat = 0;
    while (done8 !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    res = res8;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    repeat (2) @(negedge clk);
    start4 = 1'b0;
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy4); end
    n_cmp++; if (done4 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done4); end
    n_cmp++; if (res4 !== 8'h00) begin n_err++; $display("FAIL reset_result: got %h want 00", res4); end
    n_cmp++; if (busy8 !== 1'b0 || res8 !== 16'h0000) begin
      n_err++; $display("FAIL reset_w8: busy %b result %h want 0/0000", busy8, res8);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned_max;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd15; sm4 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
      n_cmp++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin
        n_err++; $display("FAIL umax_busy k=%0d: busy %b done %b want 1/0", k, busy4, done4);
      end
    end
    @(negedge clk);
    n_cmp++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      n_err++; $display("FAIL umax_done: done %b busy %b want 1/0", done4, busy4);
    end
    n_cmp++; if (res4 !== 8'hE1) begin n_err++; $display("FAIL umax_result: got %h want e1", res4); end
    @(negedge clk);
    n_cmp++; if (done4 !== 1'b0 || res4 !== 8'hE1) begin
      n_err++; $display("FAIL umax_hold: done %b result %h want 0/e1", done4, res4);
    end
  endtask

  task automatic test_vectors;
    logic [3:0] va [7] = '{4'b1101, 4'b1000, 4'b1000, 4'd7,    4'd13, 4'd0, 4'd0};
    logic [3:0] vb [7] = '{4'd5,    4'b1000, 4'd1,    4'b1111, 4'd5,  4'd5, 4'b1101};
    logic       vs [7] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0,  1'b0, 1'b1};
    logic [7:0] ve [7] = '{8'hF1,   8'h40,   8'hF8,   8'hF9,   8'h41, 8'h00, 8'h00};
    logic [7:0] r;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run4(va[i], vb[i], vs[i], r, lat);
      n_cmp++; if (r !== ve[i]) begin
        n_err++; $display("FAIL vec%0d_result: got %h want %h", i, r, ve[i]);
      end
      n_cmp++; if (lat !== 5) begin
        n_err++; $display("FAIL vec%0d_latency: got %0d want 5", i, lat);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    int extra_done;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd3; sm4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin start4 = 1'b1; a4 = 4'd7; b4 = 4'd7; end
      else start4 = 1'b0;
    end
    n_cmp++; if (lat !== 5 || res4 !== 8'h09) begin
      n_err++; $display("FAIL busy_start: latency %0d result %h want 5/09", lat, res4);
    end
    extra_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done4 === 1'b1) extra_done++;
    end
    n_cmp++; if (extra_done !== 0 || busy4 !== 1'b0 || res4 !== 8'h09) begin
      n_err++; $display("FAIL busy_second_op: extra dones %0d busy %b result %h want 0/0/09",
                        extra_done, busy4, res4);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    int lat;
    int k;
    run4(4'd2, 4'd3, 1'b0, r, lat);
    n_cmp++; if (r !== 8'h06 || lat !== 5) begin
      n_err++; $display("FAIL b2b_first: result %h latency %0d want 06/5", r, lat);
    end
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd5; sm4 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      k++;
    end while (done4 !== 1'b1 && k < 20);
    n_cmp++; if (k !== 6) begin n_err++; $display("FAIL b2b_spacing: got %0d want 6", k); end
    n_cmp++; if (res4 !== 8'h19) begin n_err++; $display("FAIL b2b_second: got %h want 19", res4); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd9; sm4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_cmp++; if (busy4 !== 1'b0 || done4 !== 1'b0 || res4 !== 8'h00) begin
      n_err++; $display("FAIL midreset: busy %b done %b result %h want 0/0/00", busy4, done4, res4);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin
      n_err++; $display("FAIL midreset_quiet: activity cycles %0d want 0", seen);
    end
  endtask

  task automatic test_sweep_w8;
    logic [7:0]  a, b;
    logic        sm;
    logic [15:0] ea, eb, exp, r;
    int lat;
    for (int i = 0; i < 400; i++) begin
      case (i)
        0: begin a = 8'd255; b = 8'd255; sm = 1'b0; end
        1: begin a = 8'h80;  b = 8'h80;  sm = 1'b1; end
        2: begin a = 8'h80;  b = 8'h7F;  sm = 1'b1; end
        3: begin a = 8'h00;  b = 8'hFF;  sm = 1'b1; end
        default: begin
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          sm = (i >= 200);
        end
      endcase
      ea = sm ? {{8{a[7]}}, a} : {8'h00, a};
      eb = sm ? {{8{b[7]}}, b} : {8'h00, b};
      exp = ea * eb;
      run8(a, b, sm, r, lat);
      n_cmp++; if (r !== exp || lat !== 9 || busy8 !== 1'b0) begin
        n_err++; $display("FAIL w8_%0d a=%h b=%h s=%b: result %h latency %0d busy %b want %h/9/0",
                          i, a, b, sm, r, lat, busy8, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_max;
    test_vectors;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid;
    test_sweep_w8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
